// File: rtl/mac8_fu.sv
// mac8_fu: signed 4-lane int8 dot-product multiply-accumulate FU, two pipeline stages.
// Define MAC8_SAT_EN to make MAC8_ACC saturate instead of wrapping.
package mac8_fu_pkg;
  localparam int unsigned XLEN = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  typedef enum logic [3:0] {NONE, ALU, MULT, MAC8} fu_t;
  typedef enum logic [7:0] {ADD, SUB, MAC8_INIT, MAC8_ACC} fu_op;
  typedef struct packed {
    fu_t                      fu;
    fu_op                     operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;
  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;
endpackage

module mac8_fu
  import mac8_fu_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     mac8_FU_valid_i,
  input  fu_data_t                 fu_data_i,
  output logic [31:0]              mac8_FU_result_o,
  output logic                     mac8_FU_valid_o,
  output logic                     mac8_FU_ready_o,
  output logic [TRANS_ID_BITS-1:0] mac8_FU_trans_id_o,
  output exception_t               mac8_FU_exception_o
);
  logic signed [15:0] p_d [4];
  logic signed [15:0] p_q [4];
  fu_op op_q;
  logic [TRANS_ID_BITS-1:0] tid_q;
  logic v1;
  logic signed [17:0] dot;
  logic [31:0] acc, acc_d, dext, sum, acc_add;
  logic unused_ok;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign p_d[i] = 16'($signed(fu_data_i.operand_a[8*i+:8])) * 16'($signed(fu_data_i.operand_b[8*i+:8]));
  end
  assign dot = 18'(p_q[0]) + 18'(p_q[1]) + 18'(p_q[2]) + 18'(p_q[3]);
  assign dext = 32'(dot);
  assign sum = acc + dext;
`ifdef MAC8_SAT_EN
  // same-sign operands giving a different-sign sum clamp toward the operands' sign
  assign acc_add = (acc[31] == dext[31] && sum[31] != acc[31]) ? {acc[31], {31{~acc[31]}}} : sum;
`else
  assign acc_add = sum;
`endif
  assign acc_d = op_q == MAC8_INIT ? dext : op_q == MAC8_ACC ? acc_add : acc;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1 <= 1'b0;
      op_q <= ADD;
      tid_q <= '0;
      p_q <= '{default: '0};
    end else begin
      v1 <= mac8_FU_valid_i;
      if (mac8_FU_valid_i) begin
        p_q <= p_d;
        op_q <= fu_data_i.operation;
        tid_q <= fu_data_i.trans_id;
      end
    end
  end
  // the result port is the accumulator itself: it only moves when an op completes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mac8_FU_valid_o <= 1'b0;
      acc <= '0;
      mac8_FU_trans_id_o <= '0;
    end else begin
      mac8_FU_valid_o <= v1;
      if (v1) begin
        acc <= acc_d;
        mac8_FU_trans_id_o <= tid_q;
      end
    end
  end
  assign mac8_FU_result_o = acc;
  assign mac8_FU_ready_o = rst_ni;
  assign mac8_FU_exception_o = '0;
  assign unused_ok = ^{fu_data_i.fu, fu_data_i.operand_a[63:32], fu_data_i.operand_b[63:32], fu_data_i.imm};
endmodule

// File: tb/tb_mac8_fu.sv
// tb_mac8_fu: randomized and directed checks of mac8_fu against an arithmetic reference model.
module tb_mac8_fu;
  import mac8_fu_pkg::*;
  typedef struct {
    logic [31:0]              res;
    logic [TRANS_ID_BITS-1:0] tid;
    int                       due;
  } exp_t;
  localparam logic [31:0] A = 32'h55667788, B = 32'h11223344;
  logic clk_i = 1'b0, rst_ni = 1'b0, valid = 1'b0;
  fu_data_t fu = '0;
  logic [31:0] result;
  logic v_o, rdy;
  logic [TRANS_ID_BITS-1:0] tid_o;
  exception_t exc;
  exp_t q[$];
  logic [31:0] got_q[$];
  logic [31:0] acc_m = '0, last_res = '0;
  logic [TRANS_ID_BITS-1:0] last_tid = '0, tid_n = '0;
  int cyc = 0, n_cmp = 0, n_err = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  mac8_fu dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mac8_FU_valid_i(valid), .fu_data_i(fu),
    .mac8_FU_result_o(result), .mac8_FU_valid_o(v_o), .mac8_FU_ready_o(rdy),
    .mac8_FU_trans_id_o(tid_o), .mac8_FU_exception_o(exc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += $signed(a[8*i+:8]) * $signed(b[8*i+:8]);
    return s;
  endfunction

  task automatic sample();
    if (q.size() != 0 && q[0].due == cyc) begin
      check("valid", v_o, 1);
      check("result", result, q[0].res);
      check("trans_id", tid_o, q[0].tid);
      got_q.push_back(result);
      last_res = q[0].res;
      last_tid = q[0].tid;
      void'(q.pop_front());
    end else begin
      check("idle_valid", v_o, 0);
      check("hold_result", result, last_res);
      check("hold_tid", tid_o, last_tid);
    end
    check("ready", rdy, rst_ni);
    check("exc", {exc.valid, |exc.cause, |exc.tval}, 0);
  endtask

  task automatic step(input logic v, input fu_op op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    logic [31:0] d;
    @(negedge clk_i);
    sample();
    valid = v;
    fu.fu = MAC8;
    fu.operation = op;
    fu.operand_a = {$urandom(), a};
    fu.operand_b = {$urandom(), b};
    fu.imm = {$urandom(), $urandom()};
    fu.trans_id = tid_n;
    if (v && rst_ni) begin
      d = dot4(a, b);
      if (op == MAC8_INIT) acc_m = d;
      else if (op == MAC8_ACC) begin
        s = longint'($signed(acc_m)) + longint'($signed(d));
`ifdef MAC8_SAT_EN
        if (s > longint'(32'sh7fffffff)) s = longint'(32'sh7fffffff);
        else if (s < -longint'(32'sh7fffffff) - 1) s = -longint'(32'sh7fffffff) - 1;
`endif
        acc_m = s[31:0];
      end
      q.push_back('{acc_m, tid_n, cyc + 2});
      tid_n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, ADD, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    sample();
    rst_ni = 1'b0;
    valid = 1'b0;
    q.delete();
    acc_m = '0;
    last_res = '0;
    last_tid = '0;
    repeat (2) begin
      @(negedge clk_i);
      sample();
    end
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_l[$];
    fu_op op;
    int r;
    idle(3);
    rst_ni = 1'b1;
    idle(2);
    got_q.delete();
    step(1'b1, MAC8_INIT, A, B); idle(3);
    step(1'b1, MAC8_INIT, A, B);
    repeat (3) step(1'b1, MAC8_ACC, A, B);
    idle(3);
    step(1'b1, MAC8_INIT, A, B); idle(2);
    step(1'b1, MAC8_ACC, A, B); idle(1);
    step(1'b1, MAC8_ACC, A, B); idle(3);
    step(1'b1, MAC8_INIT, 32'h80808080, 32'h80808080);
    step(1'b1, MAC8_INIT, 32'h80808080, 32'h7F7F7F7F);
    idle(3);
    step(1'b1, MAC8_ACC, A, B);
    do_reset();
    step(1'b1, MAC8_ACC, A, B); idle(3);
    exp_l = '{32'h0B06, 32'h0B06, 32'h160C, 32'h2112, 32'h2C18, 32'h0B06, 32'h160C, 32'h2112,
              32'h00010000, 32'hFFFF0200, 32'h0B06};
    check("dir_count", got_q.size(), exp_l.size());
    for (int i = 0; i < exp_l.size(); i++)
      check($sformatf("dir%0d", i), i < got_q.size() ? got_q[i] : 32'hx, exp_l[i]);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r == 0) do_reset();
      else begin
        case ($urandom_range(0, 5))
          0: op = ADD;
          1: op = SUB;
          2: op = MAC8_INIT;
          default: op = MAC8_ACC;
        endcase
        step(r < 75, op, $urandom(), $urandom());
      end
    end
    idle(4);
    check("drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
